// File: rtl/video_pkg.sv
// video_pkg: shared definitions for the PSRAM-side video fetch path.
//
// Contents
//   DEF_H_RES / DEF_V_RES / DEF_BURST / DEF_ADDR_W : default geometry
//   BLACK          : RGB888 value written for lines outside the frame
//   fetch_state_t  : line_fetcher FSM states
//   rgb565_to_888  : bit-replicating RGB565 -> RGB888 expansion
//
// Latency note for line_fetcher: the y_pos*H_RES product is formed
// combinationally in the IDLE cycle that sees the request pulse, so
// there is no extra register. A line_request sampled high at edge N
// gives the request pulse after edge N+1. The FSM leaves IDLE at edge
// N+2. The first mem_req, or the first BLANK write, is therefore
// visible in the cycle that follows edge N+2 ("cycle N+3").
package video_pkg;

  localparam int DEF_H_RES  = 800;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_BURST  = 16;
  localparam int DEF_ADDR_W = 22;

  localparam logic [23:0] BLACK = 24'h000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_BLANK
  } fetch_state_t;

  // Replicate each channel's top bits into the new LSBs, so that full
  // scale maps to 8'hFF and zero maps to 8'h00.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = pix[15:11];
    g = pix[10:5];
    b = pix[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

endpackage

// File: rtl/req_edge_sync.sv
// req_edge_sync: carries a single-bit level from the pixel domain into
// clk_psram and emits a one-cycle pulse on each rising edge. It can be
// reused for any pixel-to-PSRAM single-bit event.
//
// Ports
//   clk_psram : destination clock
//   rst_n     : synchronous active-low reset; clears all three flops
//   level     : asynchronous input level
//   pulse     : one clk_psram cycle high per rising edge of level
module req_edge_sync (
  input  logic clk_psram,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic meta;
  logic synced;
  logic last;

  always_ff @(posedge clk_psram) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      last   <= 1'b0;
    end else begin
      meta   <= level;
      synced <= meta;
      last   <= synced;
    end
  end

  assign pulse = synced & ~last;

endmodule

// File: rtl/line_fetcher.sv
// line_fetcher: on each line request from the pixel domain, reads one
// display line of RGB565 pixels from the PSRAM framebuffer in BURST-pixel
// bursts and writes the RGB888-expanded pixels into the line buffer.
// Lines at or beyond V_RES are filled with black without touching memory.
//
// Ports
//   clk_psram, rst_n      : clock, synchronous active-low reset
//   line_request          : async level; rising edge requests one line
//   y_pos                 : line number to fetch, sampled on the request
//   fb_base               : framebuffer base pixel address
//   mem_req/mem_addr      : burst read request and start pixel address
//   mem_ready             : request accepted when mem_req & mem_ready
//   mem_rvalid/mem_rdata  : read beat strobe and RGB565 data
//   wr_addr/wr_data/wr_en : line-buffer write port
//   busy                  : a line is in progress
//   overrun               : one-cycle pulse when a request is dropped
module line_fetcher
  import video_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int BURST  = DEF_BURST,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_psram,
  input  logic              rst_n,
  input  logic              line_request,
  input  logic [9:0]        y_pos,
  input  logic [ADDR_W-1:0] fb_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic [9:0]        wr_addr,
  output logic [23:0]       wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              overrun
);

  // x_base doubles as the pixel counter in BLANK, so it must reach H_RES.
  localparam int XW = $clog2(H_RES + 1);
  localparam int BW = $clog2(BURST + 1);

  logic req_pulse;

  req_edge_sync u_req_sync (
    .clk_psram (clk_psram),
    .rst_n     (rst_n),
    .level     (line_request),
    .pulse     (req_pulse)
  );

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] line_addr;
  logic [XW-1:0]     x_base;
  logic [BW-1:0]     beat;

  logic              vld_p1;
  logic [9:0]        addr_p1;
  logic [23:0]       data_p1;

  logic              in_frame;
  logic              beat_last;
  logic              line_last;
  logic              blank_last;

  assign in_frame   = (32'(y_pos) < V_RES);
  assign beat_last  = (beat == BW'(BURST - 1));
  assign line_last  = (x_base == XW'(H_RES - BURST));
  assign blank_last = (x_base == XW'(H_RES - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_pulse) begin
          state_next = in_frame ? ST_REQ : ST_BLANK;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem_rvalid && beat_last) begin
          state_next = line_last ? ST_IDLE : ST_REQ;
        end
      end
      ST_BLANK: begin
        if (blank_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: FSM control, burst bookkeeping and the registered
  // line-buffer write.
  always_ff @(posedge clk_psram) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      line_addr <= '0;
      x_base    <= '0;
      beat      <= '0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= '0;
    end else begin
      state  <= state_next;
      vld_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_pulse) begin
            x_base    <= '0;
            beat      <= '0;
            line_addr <= fb_base + ADDR_W'(y_pos) * ADDR_W'(H_RES);
            // The first black pixel goes out on the transition itself so
            // that BLANK output starts with the same latency as mem_req.
            if (!in_frame) begin
              vld_p1  <= 1'b1;
              addr_p1 <= '0;
              data_p1 <= BLACK;
              x_base  <= XW'(1);
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            beat <= '0;
          end
        end
        ST_DATA: begin
          if (mem_rvalid) begin
            vld_p1  <= 1'b1;
            addr_p1 <= 10'(x_base + XW'(beat));
            data_p1 <= rgb565_to_888(mem_rdata);
            if (beat_last) begin
              beat   <= '0;
              x_base <= x_base + XW'(BURST);
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        ST_BLANK: begin
          vld_p1  <= 1'b1;
          addr_p1 <= 10'(x_base);
          data_p1 <= BLACK;
          x_base  <= x_base + XW'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_req  = (state == ST_REQ);
  assign mem_addr = mem_req ? (line_addr + ADDR_W'(x_base)) : '0;
  assign busy     = (state != ST_IDLE);
  // A pulse on the very cycle the FSM is about to return to IDLE still
  // sees a non-IDLE state and is dropped as an overrun.
  assign overrun  = req_pulse & busy;

  assign wr_en    = vld_p1;
  assign wr_addr  = addr_p1;
  assign wr_data  = data_p1;

endmodule

// File: tb/tb_line_fetcher.sv
module tb_line_fetcher;

  localparam int H_RES  = 800;
  localparam int V_RES  = 480;
  localparam int BURST  = 16;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              line_request;
  logic [9:0]        y_pos;
  logic [ADDR_W-1:0] fb_base;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;
  logic [9:0]        wr_addr;
  logic [23:0]       wr_data;
  logic              wr_en;
  logic              busy;
  logic              overrun;

  always #5 clk = ~clk;

  line_fetcher #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .BURST  (BURST),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_psram    (clk),
    .rst_n        (rst_n),
    .line_request (line_request),
    .y_pos        (y_pos),
    .fb_base      (fb_base),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .busy         (busy),
    .overrun      (overrun)
  );

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  bit stall  = 1'b0;
  int acc_count = 0;
  int ovr_seen  = 0;
  int exp_ovr   = 0;
  logic [21:0] lat_addr;
  logic [33:0] exp_wr[$];
  logic [21:0] exp_burst[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Framebuffer contents as a pure function of pixel address.
  function automatic logic [15:0] mem_val(input logic [21:0] a);
    logic [31:0] h;
    case (mode)
      0: return a[15:0];
      1: begin
        case (a[1:0])
          2'd0:    return 16'hF800;
          2'd1:    return 16'h07E0;
          2'd2:    return 16'h0841;
          default: return 16'h001F;
        endcase
      end
      default: begin
        h = {10'b0, a} * 32'd40503;
        return h[22:7];
      end
    endcase
  endfunction

  // Channel expansion by arithmetic: v8 = (v << k) | (v >> (w - k)).
  function automatic logic [23:0] exp_rgb(input logic [15:0] p);
    int r, g, b;
    r = int'(p) >> 11;
    g = (int'(p) >> 5) & 63;
    b = int'(p) & 31;
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  task automatic push_line(input int y, input logic [21:0] fb);
    logic [21:0] base;
    base = 22'(int'(fb) + y * H_RES);
    if (y < V_RES) begin
      for (int k = 0; k < H_RES / BURST; k++) exp_burst.push_back(22'(int'(base) + k * BURST));
      for (int x = 0; x < H_RES; x++) exp_wr.push_back({10'(x), exp_rgb(mem_val(22'(int'(base) + x)))});
    end else begin
      for (int x = 0; x < H_RES; x++) exp_wr.push_back({10'(x), 24'h000000});
    end
  endtask

  // Memory model: accepts bursts, returns BURST beats with optional
  // stalls, and sprinkles junk rvalid while no burst is outstanding.
  initial begin
    logic        acc;
    logic        took;
    logic        rst_seen;
    logic [21:0] a;
    logic [21:0] baddr;
    int          idx;
    int          remaining;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    baddr      = '0;
    idx        = 0;
    remaining  = 0;
    forever begin
      @(negedge clk);
      acc      = mem_req && mem_ready;
      a        = mem_addr;
      took     = mem_rvalid && (remaining > 0);
      rst_seen = !rst_n;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        remaining = 0;
      end else begin
        if (took) begin
          idx++;
          remaining--;
        end
        if (acc) begin
          baddr     = a;
          idx       = 0;
          remaining = BURST;
        end
      end
      mem_ready = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
      if (remaining > 0) begin
        mem_rvalid = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
        mem_rdata  = mem_val(22'(int'(baddr) + idx));
      end else begin
        mem_rvalid = ($urandom_range(0, 99) < 20);
        mem_rdata  = 16'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (overrun) begin
          ovr_seen++;
          check("overrun_while_busy", 64'(busy), 64'(1));
        end
        if (mem_req && exp_burst.size() == 0) begin
          check("unexpected_mem_req", 64'(mem_req), 64'(0));
        end else if (mem_req && mem_ready) begin
          acc_count++;
          check("burst_addr", 64'(mem_addr), 64'(exp_burst.pop_front()));
        end
        if (wr_en) begin
          if (exp_wr.size() == 0) begin
            check("unexpected_write", 64'({wr_addr, wr_data}), 64'(0));
          end else begin
            e = exp_wr.pop_front();
            check("line_write", 64'({wr_addr, wr_data}), 64'(e));
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("line_done_in_budget", 64'(busy), 64'(0));
    @(negedge clk);
    check("writes_outstanding", 64'(exp_wr.size()), 64'(0));
    check("bursts_outstanding", 64'(exp_burst.size()), 64'(0));
  endtask

  task automatic run_line(input int y, input logic [21:0] fb);
    @(posedge clk);
    #1;
    y_pos   = 10'(y);
    fb_base = fb;
    push_line(y, fb);
    line_request = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("busy_before_start", 64'(busy), 64'(0));
    @(negedge clk);
    check("busy_at_start", 64'(busy), 64'(1));
    if (y < V_RES) begin
      check("mem_req_at_start", 64'(mem_req), 64'(1));
      lat_addr = mem_addr;
    end else begin
      check("blank_first_wen", 64'(wr_en), 64'(1));
      check("blank_first_addr", 64'(wr_addr), 64'(0));
      check("blank_no_mem_req", 64'(mem_req), 64'(0));
    end
    line_request = 1'b0;
    wait_idle(4000);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n        = 1'b0;
    line_request = 1'b0;
    y_pos        = '0;
    fb_base      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",  64'(mem_req),  64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_wr_en",    64'(wr_en),    64'(0));
    check("rst_wr_addr",  64'(wr_addr),  64'(0));
    check("rst_wr_data",  64'(wr_data),  64'(0));
    check("rst_busy",     64'(busy),     64'(0));
    check("rst_overrun",  64'(overrun),  64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    mode  = 0;
    stall = 1'b0;
    run_line(0, 22'h000000);

    mode = 1;
    run_line(7, 22'h000123);

    mode = 2;
    run_line(479, 22'h100000);
    check("line479_first_addr", 64'(lat_addr), 64'(22'h100000 + 22'd383200));
    run_line(480, 22'h2ABCDE);

    stall = 1'b1;
    run_line(470, 22'h3FF000);
    for (int i = 0; i < 4; i++) begin
      run_line(int'($urandom_range(0, 540)), 22'($urandom));
    end

    // Second request edge mid-line.
    @(posedge clk);
    #1;
    y_pos   = 10'd123;
    fb_base = 22'h0A5A5A;
    push_line(123, 22'h0A5A5A);
    line_request = 1'b1;
    base = acc_count;
    repeat (8) @(posedge clk);
    #1;
    line_request = 1'b0;
    n = 0;
    while (!(acc_count >= base + 5 && wr_en) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("overrun_mid_line", 64'(busy), 64'(1));
    @(posedge clk);
    #1;
    line_request = 1'b1;
    exp_ovr++;
    wait_idle(4000);
    line_request = 1'b0;
    repeat (40) @(negedge clk);
    check("no_refetch_busy", 64'(busy), 64'(0));
    check("overrun_count", 64'(ovr_seen), 64'(exp_ovr));

    // Reset during burst 10.
    @(posedge clk);
    #1;
    y_pos   = 10'd200;
    fb_base = 22'h01F00D;
    push_line(200, 22'h01F00D);
    line_request = 1'b1;
    base = acc_count;
    repeat (6) @(posedge clk);
    #1;
    line_request = 1'b0;
    n = 0;
    while (acc_count < base + 10 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reached_burst10", 64'(acc_count >= base + 10), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_mem_req", 64'(mem_req), 64'(0));
    check("midrst_wr_en",   64'(wr_en),   64'(0));
    check("midrst_busy",    64'(busy),    64'(0));
    exp_wr.delete();
    exp_burst.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_line(int'($urandom_range(0, 479)), 22'($urandom));

    check("overrun_total", 64'(ovr_seen), 64'(exp_ovr));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
